// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: binary-angle arctangent table, angle and gain
// constants, and the controller state encoding used by cordic and cordic_vector.
package cordic_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_e;

  // Aggregate gain of the micro-rotation sequence (limit for many iterations).
  localparam real K = 1.646760258121066;

  // Angles are referenced to a 32-bit turn (2^32 = 2*pi) and rescaled per WIDTH.
  localparam logic [31:0] ANG_PI      = 32'h8000_0000;
  localparam logic [31:0] ANG_HALF_PI = 32'h4000_0000;

  // round(atan(2^-i) / (2*pi) * 2^32)
  function automatic logic [31:0] atan_ref(input int i);
    case (i)
      0:  atan_ref = 32'h2000_0000;
      1:  atan_ref = 32'h12E4_051E;
      2:  atan_ref = 32'h09FB_385B;
      3:  atan_ref = 32'h0511_11D4;
      4:  atan_ref = 32'h028B_0D43;
      5:  atan_ref = 32'h0145_D7E1;
      6:  atan_ref = 32'h00A2_F61E;
      7:  atan_ref = 32'h0051_7C55;
      8:  atan_ref = 32'h0028_BE53;
      9:  atan_ref = 32'h0014_5F2F;
      10: atan_ref = 32'h000A_2F98;
      11: atan_ref = 32'h0005_17CC;
      12: atan_ref = 32'h0002_8BE6;
      13: atan_ref = 32'h0001_45F3;
      14: atan_ref = 32'h0000_A2FA;
      15: atan_ref = 32'h0000_517D;
      16: atan_ref = 32'h0000_28BE;
      17: atan_ref = 32'h0000_145F;
      18: atan_ref = 32'h0000_0A30;
      19: atan_ref = 32'h0000_0518;
      20: atan_ref = 32'h0000_028C;
      21: atan_ref = 32'h0000_0146;
      22: atan_ref = 32'h0000_00A3;
      23: atan_ref = 32'h0000_0051;
      24: atan_ref = 32'h0000_0029;
      25: atan_ref = 32'h0000_0014;
      26: atan_ref = 32'h0000_000A;
      27: atan_ref = 32'h0000_0005;
      28: atan_ref = 32'h0000_0003;
      29: atan_ref = 32'h0000_0001;
      30: atan_ref = 32'h0000_0001;
      default: atan_ref = 32'h0000_0000;
    endcase
  endfunction

  // Rescale a 32-bit-turn angle to a w-bit turn, rounding when narrowing.
  function automatic logic [63:0] ang_scale(input logic [31:0] a, input int w);
    logic [63:0] t;
    t = {32'd0, a};
    if (w >= 32) ang_scale = t << (w - 32);
    else         ang_scale = (t + (64'd1 << (31 - w))) >> (32 - w);
  endfunction

  function automatic logic [63:0] atan_ang(input int w, input int i);
    atan_ang = ang_scale(atan_ref(i), w);
  endfunction

endpackage

// File: rtl/cordic_vector_stage.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the
// rotated angle into z. Purely combinational; reused every iteration.
module cordic_vector_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic signed [WIDTH+1:0] x_i,
  input  logic signed [WIDTH+1:0] y_i,
  input  logic        [WIDTH-1:0] z_i,
  input  logic        [CW-1:0]    i_i,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic        [WIDTH-1:0] z_o
);

  logic signed [WIDTH+1:0] xs;
  logic signed [WIDTH+1:0] ys;
  logic        [WIDTH-1:0] atan;

  always_comb begin
    xs   = x_i >>> i_i;
    ys   = y_i >>> i_i;
    atan = WIDTH'(atan_ang(WIDTH, int'(i_i)));
    if (!y_i[WIDTH+1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) as a binary angle and
// the gain-scaled magnitude, one micro-rotation per clock.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             done,
  output logic [WIDTH-1:0] out_angle,
  output logic [WIDTH:0]   out_mag
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] PI_Z = WIDTH'(ang_scale(ANG_PI, WIDTH));

  state_e state_q, state_d;

  logic signed [XW-1:0]    x_q, x_d, y_q, y_d, sx, sy;
  logic        [WIDTH-1:0] z_q, z_d, sz;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic                    zero_q, zero_d;
  logic        [WIDTH-1:0] angle_q, angle_d;
  logic        [WIDTH:0]   mag_q, mag_d;

  cordic_vector_stage #(.WIDTH(WIDTH), .CW(CW)) u_stage (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .i_i (cnt_q),
    .x_o (sx),
    .y_o (sy),
    .z_o (sz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ITER spans ITERS rotations plus one cycle that commits the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRE;
      S_PRE:   state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(ITERS)) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb done = (state_q == S_DONE);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d    = {{2{in_x[WIDTH-1]}}, in_x};
        y_d    = {{2{in_y[WIDTH-1]}}, in_y};
        z_d    = '0;
        zero_d = 1'b0;
        cnt_d  = '0;
      end
      S_PRE: begin
        cnt_d = '0;
        // Fold the left half-plane onto the right so the rotations converge.
        if (x_q == '0 && y_q == '0) begin
          zero_d = 1'b1;
          z_d    = '0;
        end else if (x_q[XW-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = PI_Z;
        end
      end
      S_ITER: begin
        if (cnt_q != CW'(ITERS)) begin
          cnt_d = cnt_q + CW'(1);
          if (!zero_q) begin
            x_d = sx;
            y_d = sy;
            z_d = sz;
          end
        end else begin
          angle_d = z_q;
          mag_d   = x_q[WIDTH:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign out_angle = angle_q;
  assign out_mag   = mag_q;

endmodule
